fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one `synchronous_fifo` write port among `NUM_REQ` producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, muxes that producer's data onto the FIFO write port, and honours FIFO back-pressure. It sits directly in front of the FIFO's `w_en`/`data_in`/`full` pins. The read side of the FIFO is untouched.

---
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// A grant lasts until MAX_BURST words are written or the producer runs dry while the FIFO has room.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_w_en,
    output logic [DATA_WIDTH-1:0]           fifo_data_in,
    output logic                            grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_last_id;
    logic [7:0]      r_burst_cnt;

    logic [ID_W:0]   w_pick;
    logic            w_sel_found;
    logic [ID_W-1:0] w_sel_id;
    logic            w_in_grant;
    logic            w_xfer;

    // Scan from last+NUM_REQ down to last+1 so the nearest successor of last_id wins; MSB flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
        logic [ID_W:0]   result;
        logic [ID_W-1:0] cand;
        int              idx;
        result = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (valid[cand]) begin
                result = {1'b1, cand};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    assign w_pick      = rr_pick(req_valid, r_last_id);
    assign w_sel_found = w_pick[ID_W];
    assign w_sel_id    = w_pick[ID_W-1:0];
    assign w_in_grant  = (r_state == ST_GRANT);
    assign w_xfer      = w_in_grant & req_valid[r_grant_id] & ~fifo_full;

    assign grant_valid = w_in_grant;
    assign grant_id    = r_grant_id;
    assign fifo_w_en   = w_xfer;

    // Handshake and write-port mux; data is forced to zero whenever no write is issued.
    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        if (w_in_grant) begin
            req_ready[r_grant_id] = ~fifo_full;
        end else begin
            req_ready = '0;
        end
        if (w_xfer) begin
            fifo_data_in = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            fifo_data_in = '0;
        end
    end

    // Grant FSM: arbitrate in IDLE, hold through back-pressure, release on burst end or empty producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= '0;
            r_last_id   <= LAST_RST;
            r_burst_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        r_state     <= ST_GRANT;
                        r_grant_id  <= w_sel_id;
                        r_last_id   <= w_sel_id;
                        r_burst_cnt <= 8'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (fifo_full) begin
                        r_state <= ST_GRANT;
                    end else if (w_xfer) begin
                        if (r_burst_cnt == BURST_LAST) begin
                            r_state     <= ST_IDLE;
                            r_burst_cnt <= 8'd0;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 8'd1;
                        end
                    end else begin
                        // FIFO has room but the producer has nothing: give the port back.
                        r_state     <= ST_IDLE;
                        r_burst_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand sequences for
// back-pressure, fairness and reset mid-burst. A depth-8 FIFO model drives fifo_full.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    logic [7:0] fq[$];
    logic [7:0] wlog[$];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rd;
        logic [3:0]  ready;
        logic        wen;
        logic [7:0]  din;
        logic        gv;
        logic [1:0]  gid;
    } vec_t;

    vec_t tv[$];

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] valid, input logic [31:0] data, input logic rd,
                                input logic [3:0] ready, input logic wen, input logic [7:0] din,
                                input logic gv, input logic [1:0] gid);
        vec_t v;
        v.valid = valid; v.data = data; v.rd = rd; v.ready = ready;
        v.wen = wen; v.din = din; v.gv = gv; v.gid = gid;
        tv.push_back(v);
    endfunction

    // Capture write port before the edge, then update the FIFO model after it.
    task automatic tick(input logic rd);
        logic       we;
        logic [7:0] d;
        we = fifo_w_en;
        d  = fifo_data_in;
        @(posedge clk);
        if (rd && fq.size() > 0) void'(fq.pop_front());
        if (we) begin
            fq.push_back(d);
            wlog.push_back(d);
        end
        #1 fifo_full = (fq.size() == 8);
    endtask

    task automatic run_table(input string tag);
        foreach (tv[i]) begin
            req_valid = tv[i].valid;
            req_data  = tv[i].data;
            #2;
            chk($sformatf("%s[%0d] ready", tag, i), 32'(req_ready), 32'(tv[i].ready));
            chk($sformatf("%s[%0d] w_en", tag, i), 32'(fifo_w_en), 32'(tv[i].wen));
            chk($sformatf("%s[%0d] data_in", tag, i), 32'(fifo_data_in), 32'(tv[i].din));
            chk($sformatf("%s[%0d] grant_valid", tag, i), 32'(grant_valid), 32'(tv[i].gv));
            chk($sformatf("%s[%0d] grant_id", tag, i), 32'(grant_id), 32'(tv[i].gid));
            tick(tv[i].rd);
        end
        tv.delete();
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        req_data  = 32'h0;
        rst_n     = 1'b0;
        #1;
        chk("rst grant_valid", 32'(grant_valid), 32'd0);
        chk("rst w_en", 32'(fifo_w_en), 32'd0);
        fq.delete();
        wlog.delete();
        fifo_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ord [5];
        logic [1:0] prev;
        int         idx;
        logic       hs;

        rst_n     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        fifo_full = 1'b0;
        #1 rst_n = 1'b0;
        #4;
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset w_en", 32'(fifo_w_en), 32'd0);
        chk("reset data_in", 32'(fifo_data_in), 32'd0);
        chk("reset grant_valid", 32'(grant_valid), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int c = 0; c < 10; c++) begin
            #2;
            chk($sformatf("idle[%0d] grant_valid", c), 32'(grant_valid), 32'd0);
            chk($sformatf("idle[%0d] ready", c), 32'(req_ready), 32'd0);
            tick(1'b0);
        end

        // Producer 2 sends 11,22,33 then drops valid.
        add(4'b0100, 32'h00110000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        add(4'b0100, 32'h00110000, 1'b0, 4'b0100, 1'b1, 8'h11, 1'b1, 2'd2);
        add(4'b0100, 32'h00220000, 1'b0, 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2);
        add(4'b0100, 32'h00330000, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b0, 8'h00, 1'b1, 2'd2);
        add(4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2);
        run_table("single");
        chk("single fifo size", 32'(fq.size()), 32'd3);
        if (fq.size() == 3) begin
            chk("single fifo[0]", 32'(fq[0]), 32'h11);
            chk("single fifo[1]", 32'(fq[1]), 32'h22);
            chk("single fifo[2]", 32'(fq[2]), 32'h33);
        end else begin
            chk("single fifo content", 32'(fq.size()), 32'd3);
        end

        // All four producers continuously valid: bubble then 4 writes per grant.
        do_reset();
        ord  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        prev = 2'd0;
        for (int g = 0; g < 5; g++) begin
            add(4'b1111, 32'h35251505, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, prev);
            for (int w = 0; w < 4; w++) begin
                add(4'b1111, 32'h35251505, 1'b1, 4'b0001 << ord[g], 1'b1,
                    {2'b00, ord[g], 4'h5}, 1'b1, ord[g]);
            end
            prev = ord[g];
        end
        run_table("rr");
        chk("rr writes", 32'(wlog.size()), 32'd20);

        // Producer 3 served last, then 0 and 3 contend: 0 must win.
        add(4'b1000, 32'h7700000A, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        add(4'b1000, 32'h7700000A, 1'b1, 4'b1000, 1'b1, 8'h77, 1'b1, 2'd3);
        add(4'b0000, 32'h7700000A, 1'b1, 4'b1000, 1'b0, 8'h00, 1'b1, 2'd3);
        add(4'b1001, 32'h7700000A, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3);
        add(4'b1001, 32'h7700000A, 1'b1, 4'b0001, 1'b1, 8'h0A, 1'b1, 2'd0);
        add(4'b0000, 32'h7700000A, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0);
        add(4'b0000, 32'h7700000A, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        run_table("fair");

        // Back-pressure: FIFO pre-filled to 7, producer 1 bursts A0..A3.
        do_reset();
        for (int i = 0; i < 7; i++) fq.push_back(8'(8'hE0 + i));
        fifo_full = 1'b0;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx == 4 && !grant_valid) break;
            req_valid = (idx < 4) ? 4'b0010 : 4'b0000;
            req_data  = {16'h0000, 8'(8'hA0 + idx), 8'h00};
            #2;
            if (fifo_full) begin
                chk($sformatf("bp[%0d] ready while full", c), 32'(req_ready), 32'd0);
                chk($sformatf("bp[%0d] w_en while full", c), 32'(fifo_w_en), 32'd0);
            end else if (grant_valid && idx < 4) begin
                chk($sformatf("bp[%0d] w_en", c), 32'(fifo_w_en), 32'd1);
                chk($sformatf("bp[%0d] data_in", c), 32'(fifo_data_in), 32'(8'(8'hA0 + idx)));
            end else begin
                chk($sformatf("bp[%0d] idle w_en", c), 32'(fifo_w_en), 32'd0);
            end
            hs = req_valid[1] & req_ready[1];
            tick((c == 4) || (c >= 7));
            if (hs) idx++;
        end
        chk("bp words sent", 32'(idx), 32'd4);
        chk("bp grant released", 32'(grant_valid), 32'd0);
        chk("bp writes", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("bp write[%0d]", i), 32'(wlog[i]), 32'(8'(8'hA0 + i)));
        end else begin
            chk("bp write log", 32'(wlog.size()), 32'd4);
        end

        // Reset asserted in the third transfer cycle of producer 1.
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000C100;
        for (int c = 0; c < 3; c++) begin
            #2;
            tick(1'b0);
        end
        #1;
        chk("midrst w_en before", 32'(fifo_w_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst w_en", 32'(fifo_w_en), 32'd0);
        chk("midrst ready", 32'(req_ready), 32'd0);
        chk("midrst grant_valid", 32'(grant_valid), 32'd0);
        chk("midrst grant_id", 32'(grant_id), 32'd0);
        chk("midrst writes", 32'(wlog.size()), 32'd2);
        req_valid = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("postrst grant_valid", 32'(grant_valid), 32'd1);
        chk("postrst grant_id", 32'(grant_id), 32'd1);
        chk("postrst ready", 32'(req_ready), 32'b0010);
        req_valid = 4'b0000;
        tick(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
